// File: rtl/dmem_port_pkg.sv
// Shared encodings and defaults for the MEM-stage data-memory port.
package dmem_port_pkg;

   // Access FSM encodings
   typedef enum logic [1:0] {
      DMEM_IDLE    = 2'b00,
      DMEM_RD_WAIT = 2'b01,
      DMEM_WR_WAIT = 2'b10,
      DMEM_DONE    = 2'b11
   } dmem_state_e;

   // Default number of wait cycles before an unanswered access is abandoned
   localparam int unsigned DMEM_TIMEOUT = 15;

endpackage : dmem_port_pkg

// File: rtl/dmem_wait_timer.sv
// Saturating wait-cycle counter with synchronous clear, enable and a limit flag.
// o_done is high in the LIMIT-th enabled cycle after a clear.
module dmem_wait_timer #(
   parameter int unsigned LIMIT = 15,
   parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
   input  logic clock,
   input  logic reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_done
);

   localparam logic [CNT_W-1:0] C_MAX  = CNT_W'(LIMIT);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(LIMIT - 1);

   logic [CNT_W-1:0] r_cnt;

   // Count enabled cycles; hold at LIMIT so the value can never wrap
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_cnt <= '0;
      end else if (i_clr) begin
         r_cnt <= '0;
      end else if (i_en && (r_cnt != C_MAX)) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // Current cycle is the LIMIT-th one since the clear
   assign o_done = (r_cnt >= C_LAST);

endmodule : dmem_wait_timer

// File: rtl/dmem_port.sv
// MEM-stage data-memory responder: turns LW/SW control into a req/ack memory
// access, stalls the pipeline while it is outstanding, and returns load data.
module dmem_port
   import dmem_port_pkg::*;
#(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = DMEM_TIMEOUT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              MemRead,
   input  logic              MemWrite,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              stall,
   output logic              misaligned,
   output logic              bus_err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   dmem_state_e       r_state;
   dmem_state_e       w_state_nxt;
   logic [DATA_W-1:0] r_rdata;
   logic              r_bus_err;
   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [DATA_W-1:0] r_mem_wdata;

   logic w_any;
   logic w_req;
   logic w_misaligned;
   logic w_latch;
   logic w_capture;
   logic w_timeout;
   logic w_zero_rdata;
   logic w_stall;
   logic w_mem_req;
   logic w_timer_clr;
   logic w_timer_en;
   logic w_timer_done;

   assign w_any        = MemRead | MemWrite;
   assign w_req        = w_any & (addr[1:0] == 2'b00);
   assign w_misaligned = w_any & (addr[1:0] != 2'b00);

   dmem_wait_timer #(
      .LIMIT (TIMEOUT)
   ) u_timer (
      .clock  (clock),
      .reset  (reset),
      .i_clr  (w_timer_clr),
      .i_en   (w_timer_en),
      .o_done (w_timer_done)
   );

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= DMEM_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next state and per-state control strobes
   always_comb begin
      w_state_nxt  = r_state;
      w_latch      = 1'b0;
      w_capture    = 1'b0;
      w_timeout    = 1'b0;
      w_zero_rdata = 1'b0;
      w_stall      = 1'b0;
      w_mem_req    = 1'b0;
      w_timer_clr  = 1'b0;
      w_timer_en   = 1'b0;
      unique case (r_state)
         DMEM_IDLE: begin
            if (w_req) begin
               // Stall in the accept cycle so EX/MEM holds the instruction
               w_latch     = 1'b1;
               w_timer_clr = 1'b1;
               w_stall     = 1'b1;
               w_state_nxt = MemWrite ? DMEM_WR_WAIT : DMEM_RD_WAIT;
            end else if (w_misaligned) begin
               w_zero_rdata = 1'b1;
            end
         end
         DMEM_RD_WAIT, DMEM_WR_WAIT: begin
            w_mem_req  = 1'b1;
            w_stall    = 1'b1;
            w_timer_en = 1'b1;
            if (mem_ack) begin
               w_capture   = (r_state == DMEM_RD_WAIT);
               w_state_nxt = DMEM_DONE;
            end else if (w_timer_done) begin
               w_timeout   = 1'b1;
               w_state_nxt = DMEM_DONE;
            end
         end
         // One unstalled cycle; requests seen here belong to the finishing instruction
         DMEM_DONE: w_state_nxt = DMEM_IDLE;
         default:   w_state_nxt = DMEM_IDLE;
      endcase
   end

   // Request latches, load data and sticky error flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rdata     <= '0;
         r_bus_err   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
      end else begin
         if (w_latch) begin
            r_mem_we    <= MemWrite;
            r_mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            r_mem_wdata <= wdata;
         end
         if (w_capture) begin
            r_rdata <= mem_rdata;
         end else if (w_timeout || w_zero_rdata) begin
            r_rdata <= '0;
         end
         if (w_timeout) begin
            r_bus_err <= 1'b1;
         end
      end
   end

   // Stall is gated by reset so it drops without waiting for a clock edge
   assign stall      = w_stall & ~reset;
   assign mem_req    = w_mem_req;
   assign misaligned = w_misaligned;
   assign rdata      = w_zero_rdata ? '0 : r_rdata;
   assign bus_err    = r_bus_err;
   assign mem_we     = r_mem_we;
   assign mem_addr   = r_mem_addr;
   assign mem_wdata  = r_mem_wdata;

endmodule : dmem_port

// File: tb/tb_dmem_port.sv
// Directed self-checking bench for dmem_port with the default TIMEOUT of 15.
module tb_dmem_port;

   logic        clock;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        stall;
   logic        misaligned;
   logic        bus_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int n_cmp = 0;
   int n_err = 0;
   int n_pulse = 0;
   logic prev_req = 1'b0;

   dmem_port dut (
      .clock      (clock),
      .reset      (reset),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .addr       (addr),
      .wdata      (wdata),
      .rdata      (rdata),
      .stall      (stall),
      .misaligned (misaligned),
      .bus_err    (bus_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Count rising edges of mem_req
   always @(negedge clock) begin
      if (mem_req && !prev_req) n_pulse++;
      prev_req = mem_req;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Present a request from IDLE; ack in wait cycle ack_at (0 = never).
   // Returns with the DUT in DONE; reports stall-high and mem_req-high cycles.
   task automatic do_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rd,
                            output int n_stall, output int n_req);
      n_stall  = 0;
      n_req    = 0;
      MemWrite = wr;
      MemRead  = ~wr;
      addr     = a;
      wdata    = wd;
      #1;
      while (stall && n_stall < 40) begin
         n_stall++;
         if (mem_req) n_req++;
         mem_ack   = (ack_at != 0) && (n_req == ack_at);
         mem_rdata = mem_ack ? rd : 32'h0;
         tick();
      end
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
   endtask

   int ns;
   int nr;
   int p0;

   initial begin
      reset     = 1'b1;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      addr      = 32'h0;
      wdata     = 32'h0;
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      #12;
      check("rst_stall",   stall,     32'h0);
      check("rst_mem_req", mem_req,   32'h0);
      check("rst_rdata",   rdata,     32'h0);
      check("rst_bus_err", bus_err,   32'h0);
      check("rst_mem_we",  mem_we,    32'h0);
      check("rst_addr",    mem_addr,  32'h0);
      reset = 1'b0;
      tick();

      // LW 0x100, ack in the third wait cycle
      do_access(1'b0, 32'h100, 32'h0, 3, 32'hDEADBEEF, ns, nr);
      check("lw_stall_cycles", ns, 32'd4);
      check("lw_req_cycles",   nr, 32'd3);
      check("lw_done_stall",   stall, 32'h0);
      check("lw_done_rdata",   rdata, 32'hDEADBEEF);
      check("lw_mem_addr",     mem_addr, 32'h100);
      check("lw_mem_we",       mem_we, 32'h0);
      MemRead = 1'b0;
      tick();
      check("lw_rdata_hold",   rdata, 32'hDEADBEEF);
      check("idle_stall",      stall, 32'h0);

      // SW 0x204, ack in the first wait cycle
      do_access(1'b1, 32'h204, 32'h12345678, 1, 32'h0, ns, nr);
      check("sw_stall_cycles", ns, 32'd2);
      check("sw_mem_we",       mem_we, 32'h1);
      check("sw_mem_wdata",    mem_wdata, 32'h12345678);
      check("sw_mem_addr",     mem_addr, 32'h204);
      check("sw_bus_err",      bus_err, 32'h0);
      MemWrite = 1'b0;
      tick();

      // Back-to-back LW then SW, SW presented during DONE
      p0 = n_pulse;
      do_access(1'b0, 32'h300, 32'h0, 2, 32'hCAFEF00D, ns, nr);
      check("b2b_lw_stall",    ns, 32'd3);
      MemRead  = 1'b0;
      MemWrite = 1'b1;
      addr     = 32'h304;
      wdata    = 32'hA5A5A5A5;
      #1;
      check("b2b_done_stall",  stall, 32'h0);
      check("b2b_done_rdata",  rdata, 32'hCAFEF00D);
      tick();
      check("b2b_idle_stall",  stall, 32'h1);
      check("b2b_idle_req",    mem_req, 32'h0);
      do_access(1'b1, 32'h304, 32'hA5A5A5A5, 1, 32'h0, ns, nr);
      check("b2b_sw_stall",    ns, 32'd2);
      check("b2b_sw_wdata",    mem_wdata, 32'hA5A5A5A5);
      MemWrite = 1'b0;
      tick();
      tick();
      check("b2b_req_pulses",  n_pulse - p0, 32'd2);

      // LW with no ack: timeout after 15 request cycles
      do_access(1'b0, 32'h400, 32'h0, 0, 32'h0, ns, nr);
      check("to_req_cycles",   nr, 32'd15);
      check("to_stall_cycles", ns, 32'd16);
      check("to_mem_req_low",  mem_req, 32'h0);
      check("to_bus_err",      bus_err, 32'h1);
      check("to_rdata",        rdata, 32'h0);
      MemRead = 1'b0;
      tick();

      // Misaligned LW
      p0 = n_pulse;
      MemRead = 1'b1;
      addr    = 32'h103;
      #1;
      check("mis_flag",        misaligned, 32'h1);
      check("mis_stall",       stall, 32'h0);
      check("mis_rdata",       rdata, 32'h0);
      tick();
      tick();
      check("mis_no_req",      mem_req, 32'h0);
      MemRead = 1'b0;
      addr    = 32'h0;
      tick();
      check("mis_flag_clr",    misaligned, 32'h0);
      check("mis_pulses",      n_pulse - p0, 32'd0);

      // Good access after the timeout: bus_err stays sticky
      do_access(1'b0, 32'h500, 32'h0, 1, 32'h11223344, ns, nr);
      check("post_to_stall",   ns, 32'd2);
      check("post_to_rdata",   rdata, 32'h11223344);
      check("post_to_bus_err", bus_err, 32'h1);
      MemRead = 1'b0;
      tick();

      // Reset in RD_WAIT, then a late ack
      MemRead = 1'b1;
      addr    = 32'h600;
      tick();
      check("rw_mem_req",      mem_req, 32'h1);
      check("rw_stall",        stall, 32'h1);
      #2;
      reset = 1'b1;
      #1;
      check("ar_mem_req",      mem_req, 32'h0);
      check("ar_stall",        stall, 32'h0);
      check("ar_rdata",        rdata, 32'h0);
      check("ar_bus_err",      bus_err, 32'h0);
      MemRead = 1'b0;
      addr    = 32'h0;
      tick();
      reset = 1'b0;
      tick();
      mem_ack   = 1'b1;
      mem_rdata = 32'hBAD0BAD0;
      tick();
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      tick();
      check("late_ack_rdata",  rdata, 32'h0);
      check("late_ack_req",    mem_req, 32'h0);
      check("late_ack_stall",  stall, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_dmem_port
